// File: rtl/lc_expansion_banker.sv
// Language Card + Saturn 16K card + RAMWorks aux bank mapper: CPU/video address to flat SDRAM address.
// Soft-switch state updates one cycle after its bus_strobe edge; address outputs are combinational; no backpressure.
module lc_expansion_banker #(
    parameter int SAT_SLOT  = 5,
    parameter int SAT_BANKS = 8,
    parameter int AUX_BANKS = 16,
    parameter int RAM_AW    = 22
) (
    input  logic              mclk28,
    input  logic              reset_n,
    input  logic              bus_strobe,
    input  logic [15:0]       addr,
    input  logic [7:0]        din,
    input  logic              we,
    input  logic              PAGE2,
    input  logic              HIRES,
    input  logic              RAMRD,
    input  logic              RAMWRT,
    input  logic              STORE80,
    input  logic              ALTZP,
    input  logic [15:0]       video_addr,
    input  logic              video_aux,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_AW-1:0] video_ram_addr,
    output logic              card_ram_rd,
    output logic              card_ram_we,
    output logic              bank1,
    output logic              sat_active
);

    localparam logic [11:0] SAT_PAGE = 12'hC08 + 12'(SAT_SLOT);
    localparam logic [2:0]  SB_MASK  = (SAT_BANKS > 0) ? 3'(SAT_BANKS - 1) : 3'd0;
    localparam logic [7:0]  AUX_MASK = 8'(AUX_BANKS - 1);

    logic       r_bank1, r_read_en, r_write_en, r_pre_wr;
    logic       r_bankb, r_sat_read_en, r_sat_write_en, r_sat_pre_wr;
    logic [2:0] r_sat_bank;
    logic [7:0] r_aux_bank;

    logic              w_lc_hit, w_sat_hit, w_aux_wr;
    logic              w_hi_area, w_fold, w_aux;
    logic [13:0]       w_card_off;
    logic [15:0]       w_cpu_off;
    logic [RAM_AW-1:0] w_aux_base;

    assign w_lc_hit  = bus_strobe && (addr[15:4] == 12'hC08);
    assign w_sat_hit = bus_strobe && (addr[15:4] == SAT_PAGE) && (SAT_BANKS != 0);
    assign w_aux_wr  = bus_strobe && we && (addr == 16'hC073);

    // Two consecutive odd reads arm writes; any even or write access disarms.
    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            r_bank1    <= 1'b0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b1;
            r_pre_wr   <= 1'b0;
        end else if (w_lc_hit) begin
            r_bank1    <= addr[3];
            r_read_en  <= ~(addr[0] ^ addr[1]);
            r_pre_wr   <= addr[0] & ~we;
            r_write_en <= addr[0] & ~we & r_pre_wr;
        end
    end

    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            r_bankb        <= 1'b0;
            r_sat_read_en  <= 1'b0;
            r_sat_write_en <= 1'b0;
            r_sat_pre_wr   <= 1'b0;
            r_sat_bank     <= 3'd0;
        end else if (w_sat_hit) begin
            if (!addr[2]) begin
                r_bankb        <= addr[3];
                r_sat_read_en  <= ~(addr[0] ^ addr[1]);
                r_sat_pre_wr   <= addr[0] & ~we;
                r_sat_write_en <= addr[0] & ~we & r_sat_pre_wr;
            end else begin
                r_sat_bank <= {addr[3], addr[1], addr[0]} & SB_MASK;
            end
        end
    end

    always_ff @(posedge mclk28 or negedge reset_n) begin
        if (!reset_n) begin
            r_aux_bank <= 8'd0;
        end else if (w_aux_wr) begin
            r_aux_bank <= din & AUX_MASK;
        end
    end

    assign sat_active  = (r_sat_read_en | r_sat_write_en) & (SAT_BANKS != 0);
    assign card_ram_rd = sat_active ? r_sat_read_en  : r_read_en;
    assign card_ram_we = sat_active ? r_sat_write_en : r_write_en;
    assign bank1       = r_bank1;

    assign w_hi_area  = (addr >= 16'hD000);
    assign w_fold     = sat_active ? r_bankb : r_bank1;
    // Bank-1 $Dxxx lives where $Cxxx would be, since the card never maps I/O space.
    assign w_card_off = {addr[13], addr[12] & ~((addr[15:12] == 4'hD) & w_fold), addr[11:0]};
    assign w_cpu_off  = w_hi_area ? {2'b11, w_card_off} : addr;
    assign w_aux_base = RAM_AW'(32'h10000) + (RAM_AW'(r_aux_bank) << 16);

    always_comb begin
        w_aux = we ? RAMWRT : RAMRD;
        if (addr < 16'h0200 || w_hi_area) begin
            w_aux = ALTZP;
        end else if (addr[15:10] == 6'b000001 && STORE80) begin
            w_aux = PAGE2;
        end else if (addr[15:13] == 3'b001 && STORE80 && HIRES) begin
            w_aux = PAGE2;
        end
    end

    always_comb begin
        ram_addr = RAM_AW'(w_cpu_off);
        if (w_hi_area && sat_active) begin
            ram_addr = RAM_AW'(32'h200000) + (RAM_AW'(r_sat_bank) << 14) + RAM_AW'(w_card_off);
        end else if (w_aux) begin
            ram_addr = w_aux_base + RAM_AW'(w_cpu_off);
        end
    end

    assign video_ram_addr = video_aux ? RAM_AW'(32'h10000) + RAM_AW'(video_addr) : RAM_AW'(video_addr);

endmodule

// File: tb/tb_lc_expansion_banker.sv
// Bench for lc_expansion_banker: directed scenarios then randomized bus cycles against a behavioural model.
module tb_lc_expansion_banker;

    logic        mclk28 = 1'b0;
    logic        reset_n = 1'b0;
    logic        bus_strobe = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  din = 8'h0;
    logic        we = 1'b0;
    logic        PAGE2 = 0, HIRES = 0, RAMRD = 0, RAMWRT = 0, STORE80 = 0, ALTZP = 0;
    logic [15:0] video_addr = 16'h0;
    logic        video_aux = 1'b0;

    logic [21:0] ram_addr, video_ram_addr, ram_addr_ns, video_ram_addr_ns;
    logic        card_ram_rd, card_ram_we, bank1, sat_active;
    logic        card_ram_rd_ns, card_ram_we_ns, bank1_ns, sat_active_ns;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit m_bank1, m_rd, m_wr, m_pre;
    bit m_bankb, m_srd, m_swr, m_spre;
    int m_sbank, m_aux;

    always #5 mclk28 = ~mclk28;

    lc_expansion_banker #(.SAT_SLOT(5), .SAT_BANKS(8), .AUX_BANKS(16), .RAM_AW(22)) dut (
        .mclk28(mclk28), .reset_n(reset_n), .bus_strobe(bus_strobe), .addr(addr), .din(din), .we(we),
        .PAGE2(PAGE2), .HIRES(HIRES), .RAMRD(RAMRD), .RAMWRT(RAMWRT), .STORE80(STORE80), .ALTZP(ALTZP),
        .video_addr(video_addr), .video_aux(video_aux), .ram_addr(ram_addr), .video_ram_addr(video_ram_addr),
        .card_ram_rd(card_ram_rd), .card_ram_we(card_ram_we), .bank1(bank1), .sat_active(sat_active));

    lc_expansion_banker #(.SAT_SLOT(5), .SAT_BANKS(0), .AUX_BANKS(16), .RAM_AW(22)) dut_nosat (
        .mclk28(mclk28), .reset_n(reset_n), .bus_strobe(bus_strobe), .addr(addr), .din(din), .we(we),
        .PAGE2(PAGE2), .HIRES(HIRES), .RAMRD(RAMRD), .RAMWRT(RAMWRT), .STORE80(STORE80), .ALTZP(ALTZP),
        .video_addr(video_addr), .video_aux(video_aux), .ram_addr(ram_addr_ns), .video_ram_addr(video_ram_addr_ns),
        .card_ram_rd(card_ram_rd_ns), .card_ram_we(card_ram_we_ns), .bank1(bank1_ns), .sat_active(sat_active_ns));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t addr=%h)", tag, got, exp, $time, addr);
        end
    endtask

    function automatic void model_reset();
        m_bank1 = 0; m_rd = 0; m_wr = 1; m_pre = 0;
        m_bankb = 0; m_srd = 0; m_swr = 0; m_spre = 0; m_sbank = 0;
        m_aux = 0;
    endfunction

    function automatic void model_strobe(input int a, input bit w, input int d);
        bit a0, a1, odd_rd;
        a0 = bit'(a % 2);
        a1 = bit'((a / 2) % 2);
        odd_rd = a0 && !w;
        if (a / 16 == 'hC08) begin
            m_bank1 = bit'((a / 8) % 2);
            m_rd = (a0 == a1);
            m_wr = odd_rd && m_pre;
            m_pre = odd_rd;
        end
        if (a / 16 == 'hC0D) begin
            if ((a / 4) % 2 == 0) begin
                m_bankb = bit'((a / 8) % 2);
                m_srd = (a0 == a1);
                m_swr = odd_rd && m_spre;
                m_spre = odd_rd;
            end else begin
                m_sbank = (((a / 8) % 2) * 4 + a1 * 2 + a0) % 8;
            end
        end
        if (w && a == 'hC073) m_aux = d % 16;
    endfunction

    function automatic bit model_sat(input bit sat_en);
        return sat_en && (m_srd || m_swr);
    endfunction

    function automatic int exp_cpu(input int a, input bit w, input bit sat_en);
        bit sat, fold, isaux;
        int off;
        sat = model_sat(sat_en);
        if (a >= 'hD000) begin
            fold = sat ? m_bankb : m_bank1;
            off = a - 'hC000;
            if (a < 'hE000 && fold) off -= 'h1000;
            if (sat) return 'h200000 + m_sbank * 'h4000 + off;
            return (ALTZP ? 'h10000 * (m_aux + 1) : 0) + 'hC000 + off;
        end
        if (a < 'h200) isaux = ALTZP;
        else if (a >= 'h400 && a < 'h800 && STORE80) isaux = PAGE2;
        else if (a >= 'h2000 && a < 'h4000 && STORE80 && HIRES) isaux = PAGE2;
        else isaux = w ? RAMWRT : RAMRD;
        return (isaux ? 'h10000 * (m_aux + 1) : 0) + a;
    endfunction

    task automatic check_outputs();
        bit sat;
        int vexp;
        sat = model_sat(1'b1);
        vexp = video_aux ? 'h10000 + int'(video_addr) : int'(video_addr);
        chk("ram_addr", 32'(ram_addr), 32'(exp_cpu(int'(addr), we, 1'b1)));
        chk("video_ram_addr", 32'(video_ram_addr), 32'(vexp));
        chk("sat_active", 32'(sat_active), 32'(sat));
        chk("card_ram_rd", 32'(card_ram_rd), 32'(sat ? m_srd : m_rd));
        chk("card_ram_we", 32'(card_ram_we), 32'(sat ? m_swr : m_wr));
        chk("bank1", 32'(bank1), 32'(m_bank1));
        chk("ns_ram_addr", 32'(ram_addr_ns), 32'(exp_cpu(int'(addr), we, 1'b0)));
        chk("ns_sat_active", 32'(sat_active_ns), 32'd0);
        chk("ns_card_ram_rd", 32'(card_ram_rd_ns), 32'(m_rd));
        chk("ns_card_ram_we", 32'(card_ram_we_ns), 32'(m_wr));
    endtask

    // One bus cycle: apply at negedge, check pre-edge outputs, then let the edge update state.
    task automatic access(input logic [15:0] a, input logic w, input logic [7:0] d, input logic stb);
        @(negedge mclk28);
        addr = a; we = w; din = d; bus_strobe = stb;
        #1;
        check_outputs();
        @(posedge mclk28);
        if (stb) model_strobe(int'(a), w, int'(d));
        #1;
        bus_strobe = 1'b0;
    endtask

    task automatic peek(input logic [15:0] a);
        access(a, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge mclk28);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge mclk28);
        @(negedge mclk28);
        reset_n = 1'b1;

        // Reset state
        peek(16'hD123);
        chk("rst_card_rd", 32'(card_ram_rd), 32'd0);
        chk("rst_card_we", 32'(card_ram_we), 32'd1);
        chk("rst_bank1", 32'(bank1), 32'd0);

        // LC bank 1, read+write enable
        access(16'hC08B, 1'b0, 8'h00, 1'b1);
        access(16'hC08B, 1'b0, 8'h00, 1'b1);
        peek(16'hD123);
        chk("lc_rd", 32'(card_ram_rd), 32'd1);
        chk("lc_we", 32'(card_ram_we), 32'd1);
        chk("lc_bank1", 32'(bank1), 32'd1);
        chk("lc_fold", 32'(ram_addr), 32'h00C123);
        access(16'hC08B, 1'b0, 8'h00, 1'b1);
        access(16'hC08B, 1'b1, 8'h00, 1'b1);
        peek(16'hD123);
        chk("lc_wr_clears_we", 32'(card_ram_we), 32'd0);

        // Saturn bank select then enable
        access(16'hC0D5, 1'b1, 8'h00, 1'b1);
        access(16'hC0D3, 1'b0, 8'h00, 1'b1);
        access(16'hC0D3, 1'b0, 8'h00, 1'b1);
        peek(16'hE000);
        chk("sat_active", 32'(sat_active), 32'd1);
        chk("sat_we", 32'(card_ram_we), 32'd1);
        chk("sat_addr", 32'(ram_addr), 32'h206000);
        chk("nosat_inactive", 32'(sat_active_ns), 32'd0);

        // Aux bank register and video path
        access(16'hC073, 1'b1, 8'h13, 1'b1);
        RAMRD = 1'b1;
        video_aux = 1'b1;
        video_addr = 16'h2000;
        peek(16'h4000);
        chk("aux_addr", 32'(ram_addr), 32'h044000);
        chk("video_addr", 32'(video_ram_addr), 32'h012000);
        RAMRD = 1'b0;

        // Reset mid-sequence clears pre_wr
        access(16'hC081, 1'b0, 8'h00, 1'b1);
        pulse_reset();
        access(16'hC081, 1'b0, 8'h00, 1'b1);
        peek(16'hD000);
        chk("rst_seq_we", 32'(card_ram_we), 32'd0);
        access(16'hC081, 1'b0, 8'h00, 1'b1);
        peek(16'hD000);
        chk("rst_seq_prewr", 32'(card_ram_we), 32'd1);

        // Randomized bus cycles
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2: a = 16'hC080 + 16'($urandom_range(0, 15));
                3, 4:    a = 16'hC0D0 + 16'($urandom_range(0, 15));
                5:       a = 16'hC073;
                6, 7:    a = 16'hD000 + 16'($urandom_range(0, 16'h2FFF));
                default: a = 16'($urandom_range(0, 16'hFFFF));
            endcase
            {PAGE2, HIRES, RAMRD, RAMWRT, STORE80, ALTZP} = 6'($urandom_range(0, 63));
            video_aux = 1'($urandom_range(0, 1));
            video_addr = 16'($urandom_range(0, 16'hFFFF));
            if ($urandom_range(0, 299) == 0) pulse_reset();
            access(a, 1'($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 7) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
